f_division: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/f_division.sv | 42 ++++
 tb/tb_f_division.sv | 116 +++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared helpers for the clock divider: counter sizing and parameter legality.
package clkdiv_pkg;

   // Counter width for a divide ratio; never narrower than one bit.
   function automatic int cnt_width(input int div);
      if (div <= 2) return 1;
      return $clog2(div);
   endfunction

   function automatic bit params_ok(input int div, input int high);
      return (div >= 2) && (div <= 65535) && (high >= 1) && (high < div);
   endfunction

endpackage

// File: rtl/f_division.sv
// Integer clock divider: registered clk_out, high for HIGH of every DIV clk_in cycles.
// First rising edge of clk_out lands on the first clk_in edge after rst releases.
module f_division
   import clkdiv_pkg::*;
#(
   parameter int DIV  = 4,
   parameter int HIGH = DIV / 2
) (
   input  logic clk_in,
   input  logic rst,
   output logic clk_out
);

   localparam int CW = cnt_width(DIV);
   localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] HIGH_C = CW'(HIGH);

   if (!params_ok(DIV, HIGH)) begin : g_bad_params
      $error("f_division: illegal parameters DIV=%0d HIGH=%0d (need 2<=DIV<=65535, 1<=HIGH<DIV)",
             DIV, HIGH);
   end

   logic [CW-1:0] r_cnt;
   logic          r_clk_out;
   logic [CW-1:0] w_cnt_next;

   // Reset parks the counter on the last phase so the next edge starts phase 0 (high).
   assign w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_cnt     <= LAST;
         r_clk_out <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_clk_out <= (w_cnt_next < HIGH_C);
      end
   end

   assign clk_out = r_clk_out;

endmodule

// File: tb/tb_f_division.sv
// Self-checking bench: four divider configurations against a phase-count reference model.
module tb_f_division;

   localparam int N = 4;
   localparam int DIVS  [N] = '{4, 5, 2, 8};
   localparam int HIGHS [N] = '{2, 2, 1, 3};

   logic         clk = 1'b0;
   logic [N-1:0] rst_v;
   logic [N-1:0] co;

   int tests = 0;
   int fails = 0;

   // Model state: edges seen since the last reset edge (0 = in reset).
   int n_edges [N];
   int rises   [N];
   logic prev  [N];

   always #5 clk = ~clk;

   f_division #(.DIV(4), .HIGH(2)) u_d4 (.clk_in(clk), .rst(rst_v[0]), .clk_out(co[0]));
   f_division #(.DIV(5), .HIGH(2)) u_d5 (.clk_in(clk), .rst(rst_v[1]), .clk_out(co[1]));
   f_division #(.DIV(2), .HIGH(1)) u_d2 (.clk_in(clk), .rst(rst_v[2]), .clk_out(co[2]));
   f_division #(.DIV(8), .HIGH(3)) u_d8 (.clk_in(clk), .rst(rst_v[3]), .clk_out(co[3]));

   // After the k-th edge since release, clk_out is high during the first HIGH phases of each period.
   function automatic logic model_out(input int i);
      if (n_edges[i] == 0) return 1'b0;
      return (((n_edges[i] - 1) % DIVS[i]) < HIGHS[i]) ? 1'b1 : 1'b0;
   endfunction

   task automatic step(input logic [N-1:0] r);
      logic e;
      rst_v = r;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (r[i]) n_edges[i] = 0;
         else      n_edges[i] = n_edges[i] + 1;
         e = model_out(i);
         tests++;
         assert (co[i] === e) else begin
            fails++;
            $error("FAIL clk_out[div=%0d,high=%0d] edge=%0d observed=%b expected=%b",
                   DIVS[i], HIGHS[i], n_edges[i], co[i], e);
         end
         if (co[i] === 1'b1 && prev[i] !== 1'b1) rises[i]++;
         prev[i] = co[i];
      end
   endtask

   task automatic check_count(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_v = '1;
      for (int i = 0; i < N; i++) begin
         n_edges[i] = 0;
         rises[i]   = 0;
         prev[i]    = 1'b0;
      end
      @(negedge clk);

      // Reset held 10 cycles: every output low, no edges.
      for (int c = 0; c < 10; c++) begin
         step('1);
         @(negedge clk);
      end
      check_count("rises_during_reset_div4", rises[0], 0);

      // Free run 50 cycles from release.
      for (int i = 0; i < N; i++) rises[i] = 0;
      for (int c = 0; c < 50; c++) begin
         step('0);
         @(negedge clk);
         if (c == 19) check_count("div4_rises_in_20", rises[0], 5);
      end
      check_count("div5_rises_in_50", rises[1], 10);
      check_count("div2_rises_in_50", rises[2], 25);
      check_count("div8_rises_in_50", rises[3], 7);

      // Advance until the DIV=8 model is mid high phase, then pulse its reset for one cycle.
      for (int c = 0; c < 16; c++) begin
         if (n_edges[3] > 0 && ((n_edges[3] - 1) % 8) == 1) break;
         step('0);
         @(negedge clk);
      end
      check_count("div8_mid_high_phase", ((n_edges[3] - 1) % 8), 1);
      step(4'b1000);
      @(negedge clk);
      rises[3] = 0;
      for (int c = 0; c < 24; c++) begin
         step('0);
         @(negedge clk);
      end
      check_count("div8_rises_after_midreset", rises[3], 3);

      // Randomised reset pulses on every instance.
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] r;
         for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 11) == 0);
         step(r);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
